traffic_gen_pe: RTL and testbench

//  Parametrised synthetic-traffic processing element for the X*Y mesh NoC bench; one instance per node.

---
 rtl/traffic_gen_pe_if.sv | 15 +
 rtl/traffic_gen_pe.sv | 155 +++++++++++++++
 tb/tb_traffic_gen_pe.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/traffic_gen_pe_if.sv
// Flit channels between one traffic_gen_pe node and its router port.
interface traffic_gen_pe_if #(
    parameter int W = 258
);
    logic [W-1:0] o_data;
    logic         o_valid;
    logic         i_ready;
    logic [W-1:0] i_data;
    logic         i_valid;

    // Transmit: o_data is held stable while o_valid is high and is consumed on any cycle with
    // o_valid & i_ready. Receive: every i_valid cycle delivers one flit; there is no backpressure.
    modport master (output o_data, output o_valid, input i_ready, input i_data, input i_valid);
    modport slave  (input o_data, input o_valid, output i_ready, output i_data, output i_valid);
endinterface

// File: rtl/traffic_gen_pe.sv
// Synthetic-traffic processing element for a mesh NoC: rate-limited packet generator plus
// a receive-side checker with tx/rx counters and a sticky error flag.
module traffic_gen_pe #(
    parameter int          X           = 2,
    parameter int          Y           = 2,
    parameter int          xcord       = 0,
    parameter int          ycord       = 0,
    parameter int          x_size      = 1,
    parameter int          y_size      = 1,
    parameter int          data_width  = 256,
    parameter int          total_width = x_size + y_size + data_width,
    parameter int          NUM_PACKETS = 100,
    parameter int          RATE        = 100,
    parameter int          MODE        = 0,
    parameter int          HOT_X       = 0,
    parameter int          HOT_Y       = 0,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic                    clk,
    input  logic                    rstn,
    traffic_gen_pe_if.master        noc,
    output logic                    done,
    output logic [15:0]             tx_count,
    output logic [15:0]             rx_count,
    output logic                    rx_err,
    output logic [1:0]              state_dbg
);
    typedef enum logic [1:0] {S_GEN = 2'd0, S_SEND = 2'd1, S_DONE = 2'd2} state_t;

    localparam int          PB    = x_size + y_size;
    localparam logic [31:0] XU    = 32'(X);
    localparam logic [31:0] YU    = 32'(Y);
    localparam logic [31:0] XC    = 32'(xcord);
    localparam logic [31:0] YC    = 32'(ycord);
    localparam logic [31:0] FIX_X = (MODE == 1) ? YC : (MODE == 2) ? XU - XC - 32'd1 : 32'(HOT_X);
    localparam logic [31:0] FIX_Y = (MODE == 1) ? XC : (MODE == 2) ? YU - YC - 32'd1 : 32'(HOT_Y);
    // A fixed pattern that points back at this node would be pure self-traffic, so nothing is sent.
    localparam bit          SELF_FIXED = (MODE != 0) && (FIX_X == XC) && (FIX_Y == YC);
    localparam logic [7:0]  RATE8 = 8'(RATE);
    localparam logic [15:0] NUM16 = 16'(NUM_PACKETS);
    localparam logic [15:0] LFSR_INIT = SEED ^ {8'(xcord), 8'(ycord)};

    state_t                 state, state_n;
    logic [total_width-1:0] flit, flit_n;
    logic [6:0]             acc, acc_n;
    logic [7:0]             acc_sum;
    logic [15:0]            lfsr, lfsr_n;
    logic [15:0]            seq;
    logic [31:0]            dx, dy;
    logic                   load, hs, token, acc_en;

    logic [x_size-1:0]      rx_dx;
    logic [y_size-1:0]      rx_dy;
    logic [7:0]             rx_sx, rx_sy;
    logic                   rx_bad;
    logic                   unused_bits;

    assign lfsr_n = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};

    always_comb begin
        dx = 32'(lfsr[x_size-1:0]);
        dy = 32'(lfsr[8 +: y_size]);
        if (dx >= XU) dx = dx - XU;
        if (dy >= YU) dy = dy - YU;
        if (dx == XC && dy == YC) dx = (dx + 32'd1 == XU) ? 32'd0 : dx + 32'd1;
        if (MODE != 0) begin
            dx = FIX_X;
            dy = FIX_Y;
        end
    end

    always_comb begin
        flit_n = '0;
        flit_n[x_size-1:0]      = dx[x_size-1:0];
        flit_n[x_size +: y_size] = dy[y_size-1:0];
        flit_n[PB +: 16]        = seq;
        flit_n[PB+16 +: 8]      = 8'(xcord);
        flit_n[PB+24 +: 8]      = 8'(ycord);
        for (int i = 32; i < data_width; i++) flit_n[PB+i] = lfsr[(i-32)%16];
    end

    always_comb begin
        state_n = state;
        load    = 1'b0;
        seq     = tx_count;
        hs      = (state == S_SEND) && noc.i_ready;
        // The accumulator freezes while a flit is stalled so stall cycles never bank extra tokens.
        acc_en  = (state != S_DONE) && !((state == S_SEND) && !noc.i_ready);
        acc_sum = {1'b0, acc} + RATE8;
        token   = acc_en && (acc_sum >= 8'd100);
        acc_n   = acc;
        if (acc_en) acc_n = token ? 7'(acc_sum - 8'd100) : acc_sum[6:0];
        case (state)
            S_GEN: begin
                if (SELF_FIXED) begin
                    state_n = S_DONE;
                end else if (token) begin
                    load    = 1'b1;
                    state_n = S_SEND;
                end
            end
            S_SEND: begin
                if (hs) begin
                    seq = tx_count + 16'd1;
                    if (seq == NUM16)  state_n = S_DONE;
                    else if (token)    load    = 1'b1;
                    else               state_n = S_GEN;
                end
            end
            default: state_n = S_DONE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= S_GEN;
            acc      <= '0;
            lfsr     <= LFSR_INIT;
            flit     <= '0;
            tx_count <= '0;
        end else begin
            state <= state_n;
            acc   <= acc_n;
            if (hs) tx_count <= tx_count + 16'd1;
            if (load) begin
                flit <= flit_n;
                lfsr <= lfsr_n;
            end
        end
    end

    assign noc.o_valid = (state == S_SEND);
    assign noc.o_data  = flit;
    assign done        = (state == S_DONE);
    assign state_dbg   = state;

    assign rx_dx  = noc.i_data[x_size-1:0];
    assign rx_dy  = noc.i_data[x_size +: y_size];
    assign rx_sx  = noc.i_data[PB+16 +: 8];
    assign rx_sy  = noc.i_data[PB+24 +: 8];
    assign rx_bad = (32'(rx_dx) != XC) || (32'(rx_dy) != YC) ||
                    (32'(rx_sx) >= XU) || (32'(rx_sy) >= YU) ||
                    ((32'(rx_sx) == XC) && (32'(rx_sy) == YC));
    assign unused_bits = ^{noc.i_data, dx, dy};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_count <= '0;
            rx_err   <= 1'b0;
        end else if (noc.i_valid) begin
            rx_count <= rx_count + 16'd1;
            if (rx_bad) rx_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_traffic_gen_pe.sv
// Bench for traffic_gen_pe: directed timing/pattern/reset steps on small instances plus a
// randomized-backpressure run checked against a packet-level reference model.
module tb_traffic_gen_pe;
    localparam int WA = 50;  // 1+1+48
    localparam int WC = 52;  // 2+2+48

    logic clk;
    logic rstn_a, rstn, rstn_e;
    int   errors = 0;
    int   checks = 0;

    logic        done_a, done_b, done_c, done_d, done_e;
    logic        err_a, err_b, err_c, err_d, err_e;
    logic [15:0] tx_a, tx_b, tx_c, tx_d, tx_e;
    logic [15:0] rx_a, rx_b, rx_c, rx_d, rx_e;
    logic [1:0]  sd_a, sd_b, sd_c, sd_d, sd_e;

    traffic_gen_pe_if #(.W(WA)) if_a ();
    traffic_gen_pe_if #(.W(WA)) if_b ();
    traffic_gen_pe_if #(.W(WC)) if_c ();
    traffic_gen_pe_if #(.W(WC)) if_d ();
    traffic_gen_pe_if #(.W(WC)) if_e ();

    traffic_gen_pe #(.X(2), .Y(2), .xcord(0), .ycord(0), .x_size(1), .y_size(1), .data_width(48),
                     .NUM_PACKETS(4), .RATE(100), .MODE(0)) u_a (
        .clk(clk), .rstn(rstn_a), .noc(if_a.master), .done(done_a), .tx_count(tx_a),
        .rx_count(rx_a), .rx_err(err_a), .state_dbg(sd_a));
    traffic_gen_pe #(.X(2), .Y(2), .xcord(0), .ycord(0), .x_size(1), .y_size(1), .data_width(48),
                     .NUM_PACKETS(3), .RATE(50), .MODE(3), .HOT_X(1), .HOT_Y(1)) u_b (
        .clk(clk), .rstn(rstn), .noc(if_b.master), .done(done_b), .tx_count(tx_b),
        .rx_count(rx_b), .rx_err(err_b), .state_dbg(sd_b));
    traffic_gen_pe #(.X(4), .Y(4), .xcord(1), .ycord(0), .x_size(2), .y_size(2), .data_width(48),
                     .NUM_PACKETS(5), .RATE(100), .MODE(2)) u_c (
        .clk(clk), .rstn(rstn), .noc(if_c.master), .done(done_c), .tx_count(tx_c),
        .rx_count(rx_c), .rx_err(err_c), .state_dbg(sd_c));
    traffic_gen_pe #(.X(4), .Y(4), .xcord(2), .ycord(2), .x_size(2), .y_size(2), .data_width(48),
                     .NUM_PACKETS(5), .RATE(100), .MODE(1)) u_d (
        .clk(clk), .rstn(rstn), .noc(if_d.master), .done(done_d), .tx_count(tx_d),
        .rx_count(rx_d), .rx_err(err_d), .state_dbg(sd_d));
    traffic_gen_pe #(.X(4), .Y(4), .xcord(3), .ycord(1), .x_size(2), .y_size(2), .data_width(48),
                     .NUM_PACKETS(20), .RATE(37), .MODE(0)) u_e (
        .clk(clk), .rstn(rstn_e), .noc(if_e.master), .done(done_e), .tx_count(tx_e),
        .rx_count(rx_e), .rx_err(err_e), .state_dbg(sd_e));

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: one packet from the rules for a 48-bit payload node.
    function automatic logic [15:0] lfsr_step(input logic [15:0] lf);
        logic b;
        b = lf[0] ^ lf[2] ^ lf[3] ^ lf[5];
        return {b, lf[15:1]};
    endfunction

    function automatic logic [63:0] model_flit(input int nx, input int ny, input int xc, input int yc,
                                               input int xs, input int ys, input int mode,
                                               input int hx, input int hy, input int seq,
                                               input logic [15:0] lf);
        int dx, dy;
        logic [63:0] pay;
        case (mode)
            0: begin
                dx = int'(lf) % (1 << xs);
                dy = (int'(lf) / 256) % (1 << ys);
                if (dx >= nx) dx = dx - nx;
                if (dy >= ny) dy = dy - ny;
                if (dx == xc && dy == yc) dx = (dx + 1) % nx;
            end
            1: begin dx = yc; dy = xc; end
            2: begin dx = nx - 1 - xc; dy = ny - 1 - yc; end
            default: begin dx = hx; dy = hy; end
        endcase
        pay = {16'h0, lf, 8'(yc), 8'(xc), 16'(seq)};
        return (pay << (xs + ys)) | 64'(dy << xs) | 64'(dx);
    endfunction

    function automatic logic [63:0] rx_flit(input int xs, input int ys, input int dx, input int dy,
                                            input int sx, input int sy, input int seq);
        logic [63:0] pay;
        pay = {16'h0, 16'h5A5A, 8'(sy), 8'(sx), 16'(seq)};
        return (pay << (xs + ys)) | 64'(dy << xs) | 64'(dx);
    endfunction

    // Scoreboard state for the randomized run
    logic [WC-1:0] exp_q[$];

    initial begin
        logic [15:0]   lf, lf_b, lf_c, lf_e;
        logic [WC-1:0] last_data, got;
        logic          last_valid, last_ready, r;
        int            accepted, exp_rx, sx, sy;
        logic          exp_err, bad;

        rstn_a = 1'b0; rstn = 1'b0; rstn_e = 1'b0;
        if_a.i_ready = 1'b1; if_a.i_valid = 1'b0; if_a.i_data = '0;
        if_b.i_ready = 1'b1; if_b.i_valid = 1'b0; if_b.i_data = '0;
        if_c.i_ready = 1'b1; if_c.i_valid = 1'b0; if_c.i_data = '0;
        if_d.i_ready = 1'b1; if_d.i_valid = 1'b0; if_d.i_data = '0;
        if_e.i_ready = 1'b0; if_e.i_valid = 1'b0; if_e.i_data = '0;
        repeat (3) tick();

        // Reset values
        check("a_rst_valid", 64'(if_a.o_valid), 0);
        check("a_rst_data",  64'(if_a.o_data), 0);
        check("a_rst_done",  64'(done_a), 0);
        check("a_rst_tx",    64'(tx_a), 0);
        check("a_rst_rx",    64'(rx_a), 0);
        check("a_rst_err",   64'(err_a), 0);

        // RATE=100, back-to-back burst of 4, then done
        lf = 16'hACE1;
        rstn_a = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("a_burst_valid", 64'(if_a.o_valid), 1);
            check("a_burst_flit",  64'(if_a.o_data), model_flit(2, 2, 0, 0, 1, 1, 0, 0, 0, k, lf));
            lf = lfsr_step(lf);
        end
        tick();
        check("a_end_valid", 64'(if_a.o_valid), 0);
        check("a_end_done",  64'(done_a), 1);
        check("a_end_tx",    64'(tx_a), 4);
        tick();
        check("a_done_hold", 64'(done_a), 1);

        // Receive checker: good packet, then wrong dest (sticky error)
        if_a.i_valid = 1'b1;
        if_a.i_data  = WA'(rx_flit(1, 1, 0, 0, 1, 0, 7));
        tick();
        if_a.i_valid = 1'b0;
        check("a_rx_cnt1", 64'(rx_a), 1);
        check("a_rx_err0", 64'(err_a), 0);
        if_a.i_valid = 1'b1;
        if_a.i_data  = WA'(rx_flit(1, 1, 1, 0, 1, 1, 8));
        tick();
        check("a_rx_cnt2", 64'(rx_a), 2);
        check("a_rx_err1", 64'(err_a), 1);
        if_a.i_data  = WA'(rx_flit(1, 1, 0, 0, 0, 1, 9));
        tick();
        if_a.i_valid = 1'b0;
        check("a_rx_cnt3",   64'(rx_a), 3);
        check("a_rx_sticky", 64'(err_a), 1);

        // Stall for 5 cycles, then resume; reset mid-burst and restart from seq 0
        rstn_a = 1'b0;
        #1;
        check("a_rst2_valid", 64'(if_a.o_valid), 0);
        check("a_rst2_done",  64'(done_a), 0);
        check("a_rst2_rx",    64'(rx_a), 0);
        check("a_rst2_err",   64'(err_a), 0);
        if_a.i_ready = 1'b0;
        lf = 16'hACE1;
        tick();
        rstn_a = 1'b1;
        tick();
        check("a_stall_first", 64'(if_a.o_data), model_flit(2, 2, 0, 0, 1, 1, 0, 0, 0, 0, lf));
        for (int k = 0; k < 5; k++) begin
            tick();
            check("a_stall_valid", 64'(if_a.o_valid), 1);
            check("a_stall_data",  64'(if_a.o_data), model_flit(2, 2, 0, 0, 1, 1, 0, 0, 0, 0, lf));
            check("a_stall_tx",    64'(tx_a), 0);
        end
        if_a.i_ready = 1'b1;
        for (int k = 1; k < 3; k++) begin
            tick();
            lf = lfsr_step(lf);
            check("a_resume_flit", 64'(if_a.o_data), model_flit(2, 2, 0, 0, 1, 1, 0, 0, 0, k, lf));
            check("a_resume_tx",   64'(tx_a), 64'(k));
        end
        #2;
        rstn_a = 1'b0;
        #1;
        check("a_midrst_valid", 64'(if_a.o_valid), 0);
        check("a_midrst_done",  64'(done_a), 0);
        check("a_midrst_tx",    64'(tx_a), 0);
        @(posedge clk);
        #1;
        rstn_a = 1'b1;
        lf = 16'hACE1;
        tick();
        check("a_restart_valid", 64'(if_a.o_valid), 1);
        check("a_restart_flit",  64'(if_a.o_data), model_flit(2, 2, 0, 0, 1, 1, 0, 0, 0, 0, lf));
        check("a_restart_tx",    64'(tx_a), 0);

        // RATE=50 hotspot, mode-2 complement, and self-destined transpose run side by side
        check("d_pre_done", 64'(done_d), 0);
        lf_b = 16'hACE1;
        lf_c = 16'hACE1 ^ 16'h0100;
        rstn = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            tick();
            if ((t % 2 == 0) && (t <= 6)) begin
                check("b_valid", 64'(if_b.o_valid), 1);
                check("b_flit",  64'(if_b.o_data), model_flit(2, 2, 0, 0, 1, 1, 3, 1, 1, t/2 - 1, lf_b));
                lf_b = lfsr_step(lf_b);
            end else begin
                check("b_idle", 64'(if_b.o_valid), 0);
            end
            check("b_done", 64'(done_b), 64'(t >= 7));
            if (t <= 5) begin
                check("c_valid", 64'(if_c.o_valid), 1);
                check("c_flit",  64'(if_c.o_data), model_flit(4, 4, 1, 0, 2, 2, 2, 0, 0, t - 1, lf_c));
                lf_c = lfsr_step(lf_c);
            end else begin
                check("c_done", 64'(done_c), 1);
            end
            check("d_done",  64'(done_d), 1);
            check("d_tx",    64'(tx_d), 0);
            check("d_valid", 64'(if_d.o_valid), 0);
        end
        check("b_tx", 64'(tx_b), 3);
        check("c_tx", 64'(tx_c), 5);

        // Randomized backpressure against the expected packet queue
        lf_e = 16'hACE1 ^ 16'h0301;
        for (int k = 0; k < 20; k++) begin
            exp_q.push_back(WC'(model_flit(4, 4, 3, 1, 2, 2, 0, 0, 0, k, lf_e)));
            lf_e = lfsr_step(lf_e);
        end
        accepted = 0;
        last_valid = 1'b0; last_ready = 1'b0; last_data = '0;
        rstn_e = 1'b1;
        for (int cyc = 0; cyc < 3000 && !done_e; cyc++) begin
            tick();
            if (last_valid && !last_ready) begin
                check("e_hold_valid", 64'(if_e.o_valid), 1);
                check("e_hold_data",  64'(if_e.o_data), 64'(last_data));
            end
            r = 1'($urandom_range(0, 1));
            if_e.i_ready = r;
            if (if_e.o_valid && r) begin
                accepted++;
                if (exp_q.size() == 0) begin
                    check("e_extra_flit", 64'(accepted), 20);
                end else begin
                    got = exp_q.pop_front();
                    check("e_flit", 64'(if_e.o_data), 64'(got));
                end
            end
            last_valid = if_e.o_valid;
            last_ready = r;
            last_data  = if_e.o_data;
        end
        check("e_done",     64'(done_e), 1);
        check("e_accepted", 64'(accepted), 20);
        check("e_tx",       64'(tx_e), 20);
        check("e_q_empty",  64'(exp_q.size()), 0);
        check("e_idle",     64'(if_e.o_valid), 0);

        // Randomized receive traffic with one illegal source in the middle
        exp_rx = 0;
        exp_err = 1'b0;
        for (int i = 0; i < 40; i++) begin
            r   = (i == 30) ? 1'b1 : 1'($urandom_range(0, 1));
            bad = (i == 30);
            sx  = bad ? int'($urandom_range(4, 255)) : int'($urandom_range(0, 3));
            sy  = int'($urandom_range(0, 3));
            if (!bad && sx == 3 && sy == 1) sx = 0;
            if_e.i_valid = r;
            if_e.i_data  = WC'(rx_flit(2, 2, 3, 1, sx, sy, i));
            tick();
            if (r) begin
                exp_rx++;
                exp_err = exp_err | bad;
            end
            check("e_rx_cnt", 64'(rx_e), 64'(exp_rx));
            check("e_rx_err", 64'(err_e), 64'(exp_err));
        end
        if_e.i_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
